vga_scan_out: RTL and testbench
===============================

# vga_scan_out

Read-side counterpart of the bus-driven frame-buffer writer: it scans the 160x120 monochrome frame buffer continuously and drives the Basys3 VGA connector at 640x480 @ 60 Hz. Each buffer pixel is shown as a 4x4 block of screen pixels. The block sits between the frame buffer's read port and the top-level VGA pins. It also gives the processor side a per-frame pulse for tear-free updates.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per screen pixel (100 MHz / 4 = 25 MHz pixel rate)
- H_VISIBLE, 640; H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal timing in pixels (total 800)
- V_VISIBLE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical timing in lines (total 525)

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  reset, synchronous, active-low
- buf_rd_addr  output  15  frame-buffer read address {V[6:0], H[7:0]}
- buf_rd_data  input  1  frame-buffer pixel, valid one clk after buf_rd_addr changes
- fg_colour  input  12  RGB 4:4:4 colour for pixel value 1
- bg_colour  input  12  RGB 4:4:4 colour for pixel value 0
- vga_hs  output  1  horizontal sync, active-low
- vga_vs  output  1  vertical sync, active-low
- vga_rgb  output  12  {R[3:0], G[3:0], B[3:0]}
- frame_start  output  1  one-clk pulse when the scan wraps to (0,0)

## Operation
- Divider `div`, 2 bits, counts 0..CLK_DIV-1. `pix_en` is asserted when div == CLK_DIV-1.
- Stage 0 (counters): on pix_en, `h` counts 0..799. At 799 it wraps to 0 and `v` increments 0..524, wrapping to 0 after 524. Both counters hold between pix_en pulses.
- Stage 0 decode (combinational from h, v):
  - hs_raw = 0 for h in [656, 751]
  - vs_raw = 0 for v in [490, 491]
  - de_raw = (h < 640) && (v < 480)
- Stage 1: on pix_en, register:
  - buf_rd_addr <= {v[8:2], h[9:2]}. Bits are taken unconditionally; the address is don't-care during blanking but must stay ≤ 15 bits wide.
  - hs_d1, vs_d1, de_d1 <= hs_raw, vs_raw, de_raw.
- Stage 2: on pix_en, register:
  - vga_rgb <= de_d1 ? (buf_rd_data ? fg_colour : bg_colour) : 12'h000
  - vga_hs <= hs_d1
  - vga_vs <= vs_d1
- fg_colour and bg_colour are sampled at stage 2. A change therefore takes effect at the next pixel and has no other side effects.
- frame_start is 1 for exactly one clk: the clk on which pix_en is high with h == 799 and v == 524, i.e. the cycle on which the counters wrap to (0,0).
- Reset, when rst_n == 0 at a clk edge:
  - div, h and v <= 0
  - buf_rd_addr <= 0
  - hs_d1, vs_d1 <= 1; de_d1 <= 0
  - vga_hs, vga_vs <= 1; vga_rgb <= 0; frame_start <= 0
- Reset mid-frame abandons the frame. After release, scanning restarts at (0,0) with no glitch pulse on the syncs.

## Timing
- pix_en period: exactly CLK_DIV clks. The first pix_en occurs on the 4th clk after rst_n goes high.
- Latency from counter state (h,v) to pins: 2 pix_en periods (8 clks). HS, VS and RGB stay mutually aligned.
- Frame-buffer read: the address is stable for CLK_DIV clks before stage 2 samples buf_rd_data. Any read latency ≤ CLK_DIV-1 clks is therefore tolerated.
- Line: 800 pixels = 3200 clks. Frame: 525 lines = 1,680,000 clks, which is 16.8 ms at 100 MHz.
- Sync pulse widths:
  - vga_hs low for 96 pixels (384 clks).
  - vga_vs low for 2 lines (6400 clks). Its falling edge is aligned to a line start (h == 0 at stage 0), delayed by 2 pixels.
- Outputs change only on pix_en clks. The exception is frame_start, which is a registered pulse decoded from stage 0.

## Test plan
- Reset: hold rst_n = 0 for 5 clks -> vga_hs = 1, vga_vs = 1, vga_rgb = 0, buf_rd_addr = 0, frame_start = 0. Release -> first pix_en on the 4th clk.
- HS timing: run 2 lines -> vga_hs falls 658 pixels after the h == 0 pix_en, stays low for exactly 384 clks, and the period is 3200 clks.
- VS/frame: run 1 full frame -> vga_vs low for exactly 6400 clks, once per 1,680,000 clks. frame_start pulses once per frame for 1 clk.
- Addressing: at h = 639, v = 479 -> buf_rd_addr = 15'h779F (V = 119, H = 159). At h = 4, v = 4 -> 15'h0101.
- Colour/blanking: model buffer returns 1 at address 15'h0000 and 0 elsewhere; fg = 12'hF00, bg = 12'h00F -> screen pixels (0..3, 0..3) = F00, other visible pixels = 00F, all blanking pixels = 000.
- Reset mid-frame: assert rst_n = 0 at v = 200 for 1 clk -> next clk outputs are at reset values. The scan restarts at (0,0), and frame_start next pulses 1,680,000 clks later.

Source files
------------

// File: rtl/vga_scan_out.sv
// Continuous scan-out of the 160x120 monochrome frame buffer as 640x480 VGA.
// Each buffer pixel becomes a 4x4 screen block; outputs sit two pixel periods behind the counters.
module vga_scan_out #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] buf_rd_addr,
    input  logic        buf_rd_data,
    input  logic [11:0] fg_colour,
    input  logic [11:0] bg_colour,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [1:0] DIV_LAST     = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [1:0] div_reg, div_next;
    logic [9:0] h_reg, h_next;
    logic [9:0] v_reg, v_next;
    logic       pix_en;
    logic       hs_raw, vs_raw, de_raw;
    logic       hs_d1_reg, vs_d1_reg, de_d1_reg;
    logic       frame_start_next;

    assign pix_en = (div_reg == DIV_LAST);

    always_comb begin
        div_next = pix_en ? 2'd0 : div_reg + 2'd1;
        h_next   = h_reg;
        v_next   = v_reg;
        if (pix_en) begin
            if (h_reg == H_LAST) begin
                h_next = 10'd0;
                v_next = (v_reg == V_LAST) ? 10'd0 : v_reg + 10'd1;
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
    end

    assign hs_raw = !((h_reg >= H_SYNC_FIRST) && (h_reg <= H_SYNC_LAST));
    assign vs_raw = !((v_reg >= V_SYNC_FIRST) && (v_reg <= V_SYNC_LAST));
    assign de_raw = (h_reg < H_VIS_END) && (v_reg < V_VIS_END);

    // Registering the look-ahead makes frame_start coincide with the wrapping pix_en clk.
    assign frame_start_next = (div_next == DIV_LAST) && (h_next == H_LAST) && (v_next == V_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg     <= 2'd0;
            h_reg       <= 10'd0;
            v_reg       <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            div_reg     <= div_next;
            h_reg       <= h_next;
            v_reg       <= v_next;
            frame_start <= frame_start_next;
        end
    end

    // Stage 1: buffer address plus timing flags, aligned with the read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_rd_addr <= 15'd0;
            hs_d1_reg   <= 1'b1;
            vs_d1_reg   <= 1'b1;
            de_d1_reg   <= 1'b0;
        end else if (pix_en) begin
            buf_rd_addr <= {v_reg[8:2], h_reg[9:2]};
            hs_d1_reg   <= hs_raw;
            vs_d1_reg   <= vs_raw;
            de_d1_reg   <= de_raw;
        end
    end

    // Stage 2: colour lookup and pin registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_rgb <= 12'h000;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
        end else if (pix_en) begin
            vga_rgb <= de_d1_reg ? (buf_rd_data ? fg_colour : bg_colour) : 12'h000;
            vga_hs  <= hs_d1_reg;
            vga_vs  <= vs_d1_reg;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomized check of vga_scan_out against a pixel-index reference model,
// using shrunken timing so several whole frames fit in a short run.
module tb_vga_scan_out;

    localparam int CD = 4;
    localparam int HV = 40, HF = 4, HS = 8, HB = 4;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] buf_rd_addr;
    logic        buf_rd_data;
    logic [11:0] fg_colour, bg_colour;
    logic        vga_hs, vga_vs;
    logic [11:0] vga_rgb;
    logic        frame_start;

    always #5 clk = ~clk;

    vga_scan_out #(
        .CLK_DIV(CD),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data),
        .fg_colour(fg_colour),
        .bg_colour(bg_colour),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_rgb(vga_rgb),
        .frame_start(frame_start)
    );

    bit mem [0:32767];

    // Frame buffer with one clk of read latency.
    always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

    int checks = 0;
    int errors = 0;
    int t = 0;
    int frames = 0;
    logic [11:0] exp_rgb;
    logic        exp_hs, exp_vs;
    logic        prev_hs, prev_vs;
    int hs_fall_t, vs_fall_t, fs_last_t, hs_prev_fall, vs_prev_fall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [14:0] addr_of(input int n);
        int idx, h, v;
        idx = n % FRAME;
        h = idx % HT;
        v = idx / HT;
        return 15'((v / 4) * 256 + (h / 4));
    endfunction

    task automatic clear_trackers();
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        hs_fall_t = -1; vs_fall_t = -1; fs_last_t = -1;
        hs_prev_fall = -1; vs_prev_fall = -1;
    endtask

    task automatic step();
        int n, idx, h, v;
        logic [14:0] exp_addr;
        logic        exp_fs;
        @(posedge clk);
        if (!rst_n) begin
            t = 0;
            exp_rgb = 12'h000;
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            clear_trackers();
        end else begin
            t++;
            // Pins after the k-th pixel strobe show the pixel scanned two strobes earlier.
            if (t % CD == 0 && t / CD >= 2) begin
                n = t / CD - 2;
                idx = n % FRAME;
                h = idx % HT;
                v = idx / HT;
                exp_hs = !(h >= HV + HF && h < HV + HF + HS);
                exp_vs = !(v >= VV + VF && v < VV + VF + VS);
                exp_rgb = (h < HV && v < VV) ? (mem[addr_of(n)] ? fg_colour : bg_colour) : 12'h000;
            end
        end
        @(negedge clk);
        exp_addr = (t / CD >= 1) ? addr_of(t / CD - 1) : 15'd0;
        exp_fs = (t % CD == CD - 1) && ((t / CD) % FRAME == FRAME - 1);
        check("pins", {2'b00, buf_rd_addr, vga_hs, vga_vs, vga_rgb, frame_start},
                      {2'b00, exp_addr, exp_hs, exp_vs, exp_rgb, exp_fs});

        if (prev_hs && !vga_hs) begin
            if (hs_prev_fall < 0) check("hs_first_fall", t, CD * (HV + HF + 2));
            else                  check("hs_period", t - hs_prev_fall, HT * CD);
            hs_prev_fall = t;
            hs_fall_t = t;
        end
        if (!prev_hs && vga_hs && hs_fall_t >= 0) check("hs_width", t - hs_fall_t, HS * CD);
        if (prev_vs && !vga_vs) begin
            if (vs_prev_fall >= 0) check("vs_period", t - vs_prev_fall, FRAME * CD);
            vs_prev_fall = t;
            vs_fall_t = t;
        end
        if (!prev_vs && vga_vs && vs_fall_t >= 0) check("vs_width", t - vs_fall_t, VS * HT * CD);
        if (frame_start) begin
            if (fs_last_t < 0) check("fs_first", t, FRAME * CD - 1);
            else               check("fs_period", t - fs_last_t, FRAME * CD);
            fs_last_t = t;
            frames++;
            $display("frame %0d: frame_start at t=%0d", frames, t);
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;

        if ($urandom_range(0, 15) == 0) fg_colour = 12'($urandom);
        if ($urandom_range(0, 15) == 0) bg_colour = 12'($urandom);
    endtask

    initial begin
        int vr;
        bit found;
        rst_n = 1'b0;
        fg_colour = 12'hF00;
        bg_colour = 12'h00F;
        for (int i = 0; i < 32768; i++) mem[i] = 1'($urandom_range(0, 1));
        clear_trackers();

        repeat (5) step();
        $display("reset held 5 clks, releasing");
        rst_n = 1'b1;
        repeat (2 * FRAME * CD + 200) step();

        vr = $urandom_range(1, VT - 2);
        found = 1'b0;
        for (int i = 0; i < FRAME * CD + 8 && !found; i++) begin
            step();
            if (t % CD == 1 && ((t / CD) % FRAME) / HT == vr && ((t / CD) % FRAME) % HT == 5)
                found = 1'b1;
        end
        check("reset_point_found", 32'(found), 32'd1);
        $display("mid-frame reset at line %0d", vr);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (FRAME * CD + 200) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
